gpio_chaser: RTL and testbench

Memory-mapped GPIO running-light peripheral, a bus responder to the CPU's `address`/`write_data`/`read_data`/`we`/`re`/`mem_busy` interface. It replaces the hard-wired LED chaser in the top level with a CPU-programmable one: period, seed pattern, rotate or bounce mode, and direction. `memory` decodes its window and forwards a local offset. After reset it shows the same default behaviour as the hard-wired chaser: a single lit bit stepping every 6,000,000 cycles.

---
 rtl/gpio_chaser_pkg.sv | 25 ++
 rtl/gpio_chaser_step.sv | 46 ++++
 rtl/gpio_chaser.sv | 138 +++++++++++++
 tb/tb_gpio_chaser.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_chaser_pkg.sv
// gpio_chaser shared definitions: register map,
// control bit positions and the step bundle.
package gpio_chaser_pkg;

  localparam logic [5:0] CHASER_CTRL    = 6'h0;
  localparam logic [5:0] CHASER_PERIOD  = 6'h1;
  localparam logic [5:0] CHASER_PATTERN = 6'h2;
  localparam logic [5:0] CHASER_STATUS  = 6'h3;
  localparam logic [5:0] CHASER_COUNT   = 6'h4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_BOUNCE  = 1;
  localparam int CTRL_DIR     = 2;
  localparam int CTRL_RESTART = 4;
  localparam int STATUS_WRAP  = 16;

  localparam logic [22:0] CHASER_PERIOD_DEF = 23'd5999999;

  typedef struct packed {
    logic [7:0] pattern;
    logic       dir;
    logic       wrap;
  } step_t;

endpackage

// File: rtl/gpio_chaser_step.sv
// chaser_step: one rotate/bounce step of the
// LED pattern, purely combinational.
module chaser_step
  import gpio_chaser_pkg::*;
(
  input  logic [7:0] pattern,
  input  logic       bounce,
  input  logic       dir,
  output step_t      nxt
);

  always_comb begin
    nxt.pattern = pattern;
    nxt.dir     = dir;
    nxt.wrap    = 1'b0;
    unique case (1'b1)
      !bounce && !dir: begin
        nxt.pattern = {pattern[6:0], pattern[7]};
        nxt.wrap    = pattern[7];
      end
      !bounce && dir: begin
        nxt.pattern = {pattern[0], pattern[7:1]};
        nxt.wrap    = pattern[0];
      end
      // a 1 about to fall off the edge reverses travel
      bounce && !dir && pattern[7]: begin
        nxt.pattern = {1'b0, pattern[7:1]};
        nxt.dir     = 1'b1;
        nxt.wrap    = 1'b1;
      end
      bounce && !dir && !pattern[7]: begin
        nxt.pattern = {pattern[6:0], 1'b0};
      end
      bounce && dir && pattern[0]: begin
        nxt.pattern = {pattern[6:0], 1'b0};
        nxt.dir     = 1'b0;
        nxt.wrap    = 1'b1;
      end
      bounce && dir && !pattern[0]: begin
        nxt.pattern = {1'b0, pattern[7:1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpio_chaser.sv
// gpio_chaser: CPU-programmable LED running light
// with a one-wait-state read port.
module gpio_chaser
  import gpio_chaser_pkg::*;
#(
  parameter logic [22:0] PERIOD_RST  = CHASER_PERIOD_DEF,
  parameter logic [7:0]  PATTERN_RST = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re,
  output logic        mem_busy,
  output logic [7:0]  gpio_out
);

  logic        en_q;
  logic        bounce_q;
  logic        dir_q;
  logic        edir_q;
  logic        wrap_q;
  logic        rd_valid;
  logic [22:0] period_q;
  logic [22:0] cnt_q;
  logic [7:0]  pattern_q;
  logic [31:0] rdata;
  logic [5:0]  sel;
  step_t       st;

  logic wr_ctrl, wr_period, wr_pattern;
  logic wr_status, restart, load, tick;
  logic unused_bits;

  assign sel         = address[7:2];
  assign unused_bits = ^{address[1:0], write_data[31:23]};

  assign wr_ctrl    = we && (sel == CHASER_CTRL);
  assign wr_period  = we && (sel == CHASER_PERIOD);
  assign wr_pattern = we && (sel == CHASER_PATTERN);
  assign wr_status  = we && (sel == CHASER_STATUS);
  assign restart    = wr_ctrl && write_data[CTRL_RESTART];
  assign load       = wr_pattern || restart;
  assign tick       = en_q && (cnt_q == period_q);

  // reset also masks the wait state so it drops at once
  assign mem_busy = rst_n && re && !rd_valid;

  chaser_step u_step (
    .pattern (gpio_out),
    .bounce  (bounce_q),
    .dir     (edir_q),
    .nxt     (st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b1;
      bounce_q  <= 1'b0;
      dir_q     <= 1'b0;
      period_q  <= PERIOD_RST;
      pattern_q <= PATTERN_RST;
    end else begin
      if (wr_ctrl) begin
        en_q     <= write_data[CTRL_EN];
        bounce_q <= write_data[CTRL_BOUNCE];
        dir_q    <= write_data[CTRL_DIR];
      end
      if (wr_period)
        period_q <= write_data[22:0];
      if (wr_pattern)
        pattern_q <= write_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= PATTERN_RST;
      edir_q   <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_pattern)
        gpio_out <= write_data[7:0];
      else if (restart)
        gpio_out <= pattern_q;
      else if (tick)
        gpio_out <= st.pattern;

      if (wr_ctrl)
        edir_q <= write_data[CTRL_DIR];
      else if (tick && !load)
        edir_q <= st.dir;

      if (tick && !load && st.wrap)
        wrap_q <= 1'b1;
      else if (wr_status && write_data[STATUS_WRAP])
        wrap_q <= 1'b0;

      if (wr_period || load || tick)
        cnt_q <= '0;
      else if (en_q)
        cnt_q <= cnt_q + 23'd1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel == CHASER_CTRL:
        rdata = {29'b0, dir_q, bounce_q, en_q};
      sel == CHASER_PERIOD:
        rdata = {9'b0, period_q};
      sel == CHASER_PATTERN:
        rdata = {24'b0, pattern_q};
      sel == CHASER_STATUS:
        rdata = {15'b0, wrap_q, 7'b0, edir_q, gpio_out};
      sel == CHASER_COUNT:
        rdata = {9'b0, cnt_q};
      default:
        rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      read_data <= '0;
    end else begin
      rd_valid <= re;
      if (re && !rd_valid)
        read_data <= rdata;
    end
  end

endmodule

// File: tb/tb_gpio_chaser.sv
// Scoreboard bench for gpio_chaser against an
// arithmetic reference model of the register map.
module tb_gpio_chaser;

  localparam logic [22:0] PRST = 23'd5999999;
  localparam logic [7:0]  GRST = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;
  logic        mem_busy;
  logic [7:0]  gpio_out;

  always #5 clk = ~clk;

  gpio_chaser #(
    .PERIOD_RST  (PRST),
    .PATTERN_RST (GRST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .we         (we),
    .re         (re),
    .mem_busy   (mem_busy),
    .gpio_out   (gpio_out)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  int m_en, m_bounce, m_dir, m_period;
  int m_pattern, m_gpio, m_edir, m_wrap, m_cnt;
  bit m_rdv;
  bit exp_busy;
  logic [31:0] exp_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1; m_bounce = 0; m_dir = 0;
    m_period = int'(PRST);
    m_pattern = int'(GRST);
    m_gpio = int'(GRST);
    m_edir = 0; m_wrap = 0; m_cnt = 0;
    m_rdv = 1'b0;
    exp_busy = 1'b0;
  endtask

  function automatic logic [31:0] mread(int sel);
    case (sel)
      0: return 32'(m_en + 2 * m_bounce + 4 * m_dir);
      1: return 32'(m_period);
      2: return 32'(m_pattern);
      3: return 32'(m_gpio + 256 * m_edir + 65536 * m_wrap);
      4: return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across the coming clock edge.
  task automatic model_edge(input bit w, input bit r,
                            input logic [7:0] a,
                            input logic [31:0] wd);
    int sel, np, nd, wrp, g;
    bit tick, wc, wp, wpat, wst, rs, ld;
    sel  = int'(a[7:2]);
    g    = m_gpio;
    exp_busy = r && !m_rdv;
    if (r && !m_rdv)
      exp_q.push_back(mread(sel));
    tick = (m_en != 0) && (m_cnt == m_period);
    wc   = w && sel == 0;
    wp   = w && sel == 1;
    wpat = w && sel == 2;
    wst  = w && sel == 3;
    rs   = wc && wd[4];
    ld   = wpat || rs;
    np = g; nd = m_edir; wrp = 0;
    if (m_bounce == 0) begin
      if (m_edir == 0) begin
        np = (g * 2) % 256 + g / 128;
        wrp = g / 128;
      end else begin
        np = g / 2 + (g % 2) * 128;
        wrp = g % 2;
      end
    end else if (m_edir == 0) begin
      if (g >= 128) begin
        nd = 1; np = g / 2; wrp = 1;
      end else np = g * 2;
    end else begin
      if (g % 2 == 1) begin
        nd = 0; np = (g * 2) % 256; wrp = 1;
      end else np = g / 2;
    end
    if (wpat) m_gpio = int'(wd[7:0]);
    else if (rs) m_gpio = m_pattern;
    else if (tick) m_gpio = np;
    if (wp || ld || tick) m_cnt = 0;
    else if (m_en != 0) m_cnt = m_cnt + 1;
    if (wc) m_edir = int'(wd[2]);
    else if (tick && !ld) m_edir = nd;
    if (tick && !ld && wrp == 1) m_wrap = 1;
    else if (wst && wd[16]) m_wrap = 0;
    if (wc) begin
      m_en = int'(wd[0]);
      m_bounce = int'(wd[1]);
      m_dir = int'(wd[2]);
    end
    if (wp) m_period = int'(wd[22:0]);
    if (wpat) m_pattern = int'(wd[7:0]);
    m_rdv = r;
  endtask

  // Entered at a negedge, returns at the next one.
  task automatic cyc(input bit w, input bit r,
                     input logic [7:0] a,
                     input logic [31:0] d);
    we = w; re = r;
    address = a; write_data = d;
    model_edge(w, r, a, d);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b0, 1'b1, a, 32'h0);
    cyc(1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (run && rst_n) begin
      check("gpio_out", 32'(gpio_out), 32'(m_gpio));
      check("busy_post", 32'(mem_busy),
            32'(re && !m_rdv));
      if (re && !mem_busy) begin
        if (exp_q.size() == 0)
          check("spurious_read", 32'(read_data), 32'hx);
        else
          check("read_data", read_data,
                exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (run && rst_n)
      check("busy_wait", 32'(mem_busy), 32'(exp_busy));
  end

  initial begin
    bit last_re, r, w;
    int sel;
    logic [31:0] d;
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0;
    address = 8'h0; write_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gpio", 32'(gpio_out), 32'h01);
    check("rst_rdata", read_data, 32'h0);
    check("rst_busy", 32'(mem_busy), 32'h0);
    rst_n = 1'b1;
    run = 1'b1;

    rd(8'h04);
    rd(8'h1C);

    wr(8'h04, 32'd3);
    rd(8'h10);
    check("p3_hold", 32'(gpio_out), 32'h01);
    rd(8'h10);
    check("p3_step1", 32'(gpio_out), 32'h02);
    idle(4);
    check("p3_step2", 32'(gpio_out), 32'h04);

    wr(8'h04, 32'd0);
    wr(8'h08, 32'h80);
    check("rot_load", 32'(gpio_out), 32'h80);
    idle(1);
    check("rot_wrap", 32'(gpio_out), 32'h01);
    rd(8'h0C);
    wr(8'h0C, 32'h10000);
    rd(8'h0C);

    wr(8'h00, 32'h3);
    wr(8'h08, 32'h40);
    check("bnc_load", 32'(gpio_out), 32'h40);
    idle(1);
    check("bnc_80", 32'(gpio_out), 32'h80);
    idle(1);
    check("bnc_rev", 32'(gpio_out), 32'h40);
    idle(1);
    check("bnc_20", 32'(gpio_out), 32'h20);
    rd(8'h0C);

    wr(8'h00, 32'h1);
    wr(8'h04, 32'd3);
    idle(3);
    wr(8'h08, 32'hA5);
    check("pat_beats_step", 32'(gpio_out), 32'hA5);
    rd(8'h10);
    wr(8'h00, 32'h0);
    idle(10);
    check("en_off_hold", 32'(gpio_out), 32'hA5);

    we = 1'b0; re = 1'b1; address = 8'h04;
    exp_busy = 1'b1;
    #1 check("mid_busy", 32'(mem_busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(mem_busy), 32'h0);
    check("arst_gpio", 32'(gpio_out), 32'h01);
    check("arst_rdata", read_data, 32'h0);
    model_reset();
    exp_q.delete();
    re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    rd(8'h04);

    wr(8'h04, 32'd2);
    last_re = 1'b0;
    repeat (3000) begin
      r = !last_re && ($urandom_range(0, 99) < 25);
      w = $urandom_range(0, 99) < 20;
      sel = int'($urandom_range(0, 7));
      d = $urandom;
      if (sel == 0 && $urandom_range(0, 4) != 0)
        d[0] = 1'b1;
      if (sel == 1)
        d = (d & 32'hFF80_0000) |
            32'($urandom_range(0, 6));
      cyc(w, r, 8'(sel * 4 + $urandom_range(0, 3)), d);
      last_re = r;
    end
    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
